// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared definitions for the parking occupancy controller and its detector:
// alarm FSM states and the entry/exit/error event bundle.
package parking_occupancy_ctrl_pkg;

  // Alarm FSM states, encoded to match the detector side.
  typedef enum logic {
    ESPERA = 1'b0,
    ALARMA = 1'b1
  } alarm_state_e;

  // Event bundle coming from the two-sensor detector.
  typedef struct packed {
    logic entra;
    logic sale;
    logic error;
  } det_ev_t;

  // Rising-edge detect on every field of the event bundle.
  function automatic det_ev_t rise(input det_ev_t cur, input det_ev_t prev);
    return det_ev_t'(cur & ~prev);
  endfunction

endpackage

// File: rtl/parking_bin2bcd.sv
// Combinational 8-bit binary to two-digit BCD. Inputs above 99 wrap the tens digit.
module parking_bin2bcd (
  input  logic [7:0] bin,
  output logic [3:0] decenas,
  output logic [3:0] unidades
);

  logic [7:0] tens;
  logic [7:0] ones;

  // Divide/modulo by a constant ten; small enough to map to plain logic.
  always_comb begin
    tens     = bin / 8'd10;
    ones     = bin % 8'd10;
    decenas  = tens[3:0];
    unidades = ones[3:0];
  end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Parking occupancy controller: counts cars from detector pulses, drives
// lleno/vacio, a timed alarm on sensor errors and sticky overflow/underflow.
// Optional BCD readout of ocupados enabled by macro PARKING_BCD_OUT_EN.
module parking_occupancy_ctrl
  import parking_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned CAPACIDAD     = 15,
  parameter int unsigned ALARMA_CICLOS = 50,
  localparam int unsigned CNT_W        = $clog2(CAPACIDAD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entra,
  input  logic             sale,
  input  logic             error,
  input  logic             ack,
  output logic [CNT_W-1:0] ocupados,
  output logic             lleno,
  output logic             vacio,
  output logic             alarma,
  output logic             overflow,
  output logic             underflow
`ifdef PARKING_BCD_OUT_EN
  ,
  output logic [3:0]       decenas,
  output logic [3:0]       unidades
`endif
);

  localparam int unsigned TMR_W = (ALARMA_CICLOS > 1) ? $clog2(ALARMA_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACIDAD);
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(ALARMA_CICLOS - 1);

  det_ev_t          in_now;
  det_ev_t          in_q;
  det_ev_t          ev;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             unf_d;
  alarm_state_e     state_q;
  alarm_state_e     state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  assign in_now = '{entra: entra, sale: sale, error: error};
  assign ev     = rise(in_now, in_q);
  assign alarma = (state_q == ALARMA);

  // Occupancy next value and sticky flag next values; a set beats ack.
  always_comb begin
    logic ovf_set;
    logic unf_set;
    cnt_d   = ocupados;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ev.entra && !ev.sale) begin
      if (ocupados == CAP) ovf_set = 1'b1;
      else                 cnt_d   = ocupados + CNT_W'(1);
    end else if (ev.sale && !ev.entra) begin
      if (ocupados == '0) unf_set = 1'b1;
      else                cnt_d   = ocupados - CNT_W'(1);
    end
    ovf_d = ovf_set | (overflow & ~ack);
    unf_d = unf_set | (underflow & ~ack);
  end

  // Alarm FSM next state; a new error always wins over ack or expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ESPERA: begin
        if (ev.error) begin
          state_d = ALARMA;
          timer_d = RELOAD;
        end
      end
      ALARMA: begin
        if (ev.error) begin
          timer_d = RELOAD;
        end else if (ack) begin
          state_d = ESPERA;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = ESPERA;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
    endcase
  end

  // Registered state: edge samples, count, status and alarm FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_q      <= '0;
      ocupados  <= '0;
      lleno     <= 1'b0;
      vacio     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      state_q   <= ESPERA;
      timer_q   <= '0;
    end else begin
      in_q      <= in_now;
      ocupados  <= cnt_d;
      lleno     <= (cnt_d == CAP);
      vacio     <= (cnt_d == '0);
      overflow  <= ovf_d;
      underflow <= unf_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
    end
  end

`ifdef PARKING_BCD_OUT_EN
  if (CAPACIDAD > 99) begin : g_cap_chk
    $error("parking_occupancy_ctrl: CAPACIDAD above 99 cannot be shown in two BCD digits");
  end

  logic [7:0] occ8;
  logic [3:0] dec_c;
  logic [3:0] uni_c;

  assign occ8 = 8'(ocupados);

  parking_bin2bcd u_bin2bcd (
    .bin      (occ8),
    .decenas  (dec_c),
    .unidades (uni_c)
  );

  // BCD digits registered from the already-registered count (one cycle behind).
  always_ff @(posedge clk) begin
    if (!reset) begin
      decenas  <= '0;
      unidades <= '0;
    end else begin
      decenas  <= dec_c;
      unidades <= uni_c;
    end
  end
`endif

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench for parking_occupancy_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a count model.
module tb_parking_occupancy_ctrl;

  localparam int CAP = 15;
  localparam int ALM = 50;

  logic       clk;
  logic       reset;
  logic       entra;
  logic       sale;
  logic       error;
  logic       ack;
  logic [3:0] ocupados;
  logic       lleno;
  logic       vacio;
  logic       alarma;
  logic       overflow;
  logic       underflow;
`ifdef PARKING_BCD_OUT_EN
  logic [3:0] decenas;
  logic [3:0] unidades;
`endif

  int checks = 0;
  int errors = 0;

  parking_occupancy_ctrl #(
    .CAPACIDAD     (CAP),
    .ALARMA_CICLOS (ALM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .entra     (entra),
    .sale      (sale),
    .error     (error),
    .ack       (ack),
    .ocupados  (ocupados),
    .lleno     (lleno),
    .vacio     (vacio),
    .alarma    (alarma),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef PARKING_BCD_OUT_EN
    ,
    .decenas   (decenas),
    .unidades  (unidades)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy as an integer, alarm as "cycles left to stay high".
  int m_cnt, m_rem, m_dec, m_uni;
  bit m_ovf, m_unf, m_pe, m_ps, m_pr, m_valid;

  always @(posedge clk) begin
    bit ee, es, er, ovs, uns;
    if (!reset) begin
      m_cnt = 0; m_rem = 0; m_dec = 0; m_uni = 0;
      m_ovf = 0; m_unf = 0; m_valid = 1;
      m_pe = 0; m_ps = 0; m_pr = 0;
    end else begin
      ee = entra && !m_pe;
      es = sale && !m_ps;
      er = error && !m_pr;
      m_dec = m_cnt / 10;
      m_uni = m_cnt % 10;
      ovs = 0;
      uns = 0;
      if (ee && !es) begin
        if (m_cnt == CAP) ovs = 1;
        else m_cnt = m_cnt + 1;
      end else if (es && !ee) begin
        if (m_cnt == 0) uns = 1;
        else m_cnt = m_cnt - 1;
      end
      m_ovf = ovs || (m_ovf && !ack);
      m_unf = uns || (m_unf && !ack);
      if (er) m_rem = ALM;
      else if (ack) m_rem = 0;
      else if (m_rem > 0) m_rem = m_rem - 1;
      m_pe = entra; m_ps = sale; m_pr = error;
    end
  end

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ocupados", 32'(ocupados), 32'(m_cnt));
      chk("lleno", 32'(lleno), 32'(m_cnt == CAP));
      chk("vacio", 32'(vacio), 32'(m_cnt == 0));
      chk("alarma", 32'(alarma), 32'(m_rem > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef PARKING_BCD_OUT_EN
      chk("decenas", 32'(decenas), 32'(m_dec));
      chk("unidades", 32'(unidades), 32'(m_uni));
`endif
    end
  end

  task automatic pulse(input bit e, input bit s, input bit r);
    entra = e; sale = s; error = r;
    @(negedge clk);
    entra = 0; sale = 0; error = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    m_valid = 0;
    reset = 0; entra = 1; sale = 0; error = 0; ack = 0;

    // Reset with entra high, then release: the held level counts once.
    repeat (2) @(negedge clk);
    chk("rst_ocupados", 32'(ocupados), 0);
    chk("rst_vacio", 32'(vacio), 1);
    chk("rst_lleno", 32'(lleno), 0);
    chk("rst_alarma", 32'(alarma), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);
    reset = 1;
    @(negedge clk);
    chk("rel_ocupados", 32'(ocupados), 1);
    entra = 0;
    @(negedge clk);

    // Fill to capacity, then overflow and acknowledge.
    repeat (14) pulse(1, 0, 0);
    chk("full_ocupados", 32'(ocupados), 15);
    chk("full_lleno", 32'(lleno), 1);
    pulse(1, 0, 0);
    chk("ovf_ocupados", 32'(ocupados), 15);
    chk("ovf_flag", 32'(overflow), 1);
    ack = 1; @(negedge clk); ack = 0;
    chk("ovf_ack", 32'(overflow), 0);

    // Drain to empty, then underflow.
    repeat (15) pulse(0, 1, 0);
    chk("empty_vacio", 32'(vacio), 1);
    pulse(0, 1, 0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_ocupados", 32'(ocupados), 0);
    ack = 1; @(negedge clk); ack = 0;
    chk("unf_ack", 32'(underflow), 0);

    // Simultaneous entry and exit at 5 leaves the count alone.
    repeat (5) pulse(1, 0, 0);
    pulse(1, 1, 0);
    chk("both_ocupados", 32'(ocupados), 5);
    chk("both_flags", {30'd0, overflow, underflow}, 0);

    // A long entra level is one car.
    entra = 1; repeat (10) @(negedge clk); entra = 0; @(negedge clk);
    chk("held_ocupados", 32'(ocupados), 6);

    // Single error: alarm high for exactly ALM cycles.
    error = 1; @(negedge clk); error = 0;
    n = 0;
    while (alarma === 1'b1 && n < 300) begin n++; @(negedge clk); end
    chk("alarm_len", 32'(n), 50);

    // Retrigger at high cycle 30.
    error = 1; @(negedge clk); error = 0;
    n = 0;
    while (alarma === 1'b1 && n < 300) begin
      n++;
      error = (n == 30);
      @(negedge clk);
    end
    error = 0;
    chk("alarm_retrig_len", 32'(n), 80);

    // Ack at high cycle 10 ends the alarm on the next cycle.
    error = 1; @(negedge clk); error = 0;
    n = 0;
    while (alarma === 1'b1 && n < 300) begin
      n++;
      ack = (n == 10);
      @(negedge clk);
    end
    ack = 0;
    chk("alarm_ack_len", 32'(n), 10);

    // Reset mid-alarm aborts it and clears the count.
    error = 1; @(negedge clk); error = 0;
    repeat (3) @(negedge clk);
    reset = 0; @(negedge clk); reset = 1;
    chk("rst_mid_alarma", 32'(alarma), 0);
    chk("rst_mid_ocupados", 32'(ocupados), 0);
    @(negedge clk);

`ifdef PARKING_BCD_OUT_EN
    // BCD follows the count one cycle later.
    repeat (11) pulse(1, 0, 0);
    entra = 1; @(negedge clk); entra = 0;
    chk("bcd_ocup12", 32'(ocupados), 12);
    chk("bcd_lag_dec", 32'(decenas), 1);
    chk("bcd_lag_uni", 32'(unidades), 1);
    @(negedge clk);
    chk("bcd_dec", 32'(decenas), 1);
    chk("bcd_uni", 32'(unidades), 2);
`endif

    // Randomized traffic with occasional errors, acks and resets.
    for (int i = 0; i < 4000; i++) begin
      entra = ($urandom_range(0, 2) == 0);
      sale  = ($urandom_range(0, 2) == 0);
      error = ($urandom_range(0, 59) == 0);
      ack   = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    reset = 1; entra = 0; sale = 0; error = 0; ack = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
